rx_eth_dispatch: RTL

GMII receive front end that parses Ethernet II frames and steers each payload to one of `NUM_CH` protocol channels selected by EtherType, such as ARP or IPv4. It is a parametrised successor to the fixed two-way split in `rx_ethernet`. It sits between the PHY GMII receive pins and the per-protocol parsers (`rx_arp`, `rx_ip`, …). It strips preamble, SFD, header and FCS, filters on destination MAC, and reports per-frame status (FCS, `RX_ER`, runt).

---
 rtl/rx_eth_dispatch.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/rx_eth_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : rx_eth_dispatch
//  Description : GMII receive front end for Ethernet II frames.  Strips the
//                preamble, SFD, MAC header and FCS.  Filters on destination
//                MAC and steers each payload byte to one of NUM_CH channels
//                selected by EtherType.  Reports a per-frame verdict covering
//                FCS, RX_ER and runt length.
//  Ports       : RX_CLK / rst            - clock, async active-high reset
//                RX_DV, RXD, RX_ER       - GMII receive pins
//                promisc                 - accept any destination MAC
//                rx_data, rx_valid       - payload byte + one-hot channel strobe
//                rx_sof                  - first payload byte of the frame
//                rx_eof, rx_good, rx_len - end-of-frame status strobe
//                rx_ch                   - selected channel, held for the frame
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_eth_dispatch #(
    parameter int                   NUM_CH   = 2,
    parameter logic [NUM_CH*16-1:0] ETYPES   = {16'h0800, 16'h0806},
    parameter logic [47:0]          MAC_ADDR = 48'h02_00_00_00_00_01,
    parameter int                   MIN_LEN  = 60,
    localparam int                  CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              RX_CLK,
    input  logic              rst,
    input  logic              RX_DV,
    input  logic [7:0]        RXD,
    input  logic              RX_ER,
    input  logic              promisc,
    output logic [7:0]        rx_data,
    output logic [NUM_CH-1:0] rx_valid,
    output logic              rx_sof,
    output logic              rx_eof,
    output logic              rx_good,
    output logic [10:0]       rx_len,
    output logic [CH_W-1:0]   rx_ch
);

    localparam logic [2:0] S_WAIT = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_PRE  = 3'd2;
    localparam logic [2:0] S_HDR  = 3'd3;
    localparam logic [2:0] S_PAY  = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [3:0]        r_cnt;        // header byte index 0..13
    logic [39:0]       r_dst;        // first five destination octets
    logic [7:0]        r_et_hi;      // EtherType high octet
    logic [31:0]       r_crc;
    logic [7:0]        r_dly [0:3];  // FCS delay line, index 0 is oldest
    logic [2:0]        r_dly_cnt;
    logic              r_err;
    logic [10:0]       r_plen;       // running payload count
    logic              r_first;      // next emitted byte is the first
    logic [7:0]        r_data;
    logic [NUM_CH-1:0] r_valid;
    logic              r_sof;
    logic              r_eof;
    logic              r_good;
    logic [10:0]       r_len;
    logic [CH_W-1:0]   r_ch;

    logic [47:0]       w_dst;
    logic              w_dst_ok;
    logic [15:0]       w_etype;
    logic              w_match;
    logic [CH_W-1:0]   w_ch_sel;
    logic              w_full;
    logic [31:0]       w_fcs;
    logic              w_good;
    logic              w_emit;
    logic              w_eof;
    logic              w_sfd;

    // Reflected IEEE 802.3 CRC-32, one byte, LSB first.
    function automatic logic [31:0] f_crc8(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c ^ {24'd0, d};
        for (int k = 0; k < 8; k++) begin
            x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
        end
        return x;
    endfunction

    // ---------------- decode / output qualifiers ----------------
    always_comb begin
        w_dst    = {r_dst, RXD};
        w_dst_ok = promisc || (w_dst == MAC_ADDR) || (w_dst == 48'hFFFF_FFFF_FFFF);
        w_etype  = {r_et_hi, RXD};
        w_match  = 1'b0;
        w_ch_sel = '0;
        // Scan downward so the lowest matching index is the one kept.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_etype == ETYPES[16*i +: 16]) begin
                w_match  = 1'b1;
                w_ch_sel = CH_W'(i);
            end
        end
        w_full = (r_dly_cnt == 3'd4);
        w_fcs  = {r_dly[3], r_dly[2], r_dly[1], r_dly[0]};
        w_good = !r_err && ((32'd14 + 32'(r_plen)) >= 32'(MIN_LEN)) && w_full
                 && (w_fcs == ~r_crc);
        w_emit = (r_state == S_PAY) && RX_DV && w_full;
        w_eof  = (r_state == S_PAY) && !RX_DV;
        w_sfd  = (r_state == S_PRE) && RX_DV && (RXD == 8'hD5);
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT: if (!RX_DV) w_next = S_IDLE;
            S_IDLE: if (RX_DV) w_next = (RXD == 8'h55) ? S_PRE : S_WAIT;
            S_PRE: begin
                if (!RX_DV)               w_next = S_IDLE;
                else if (RXD == 8'h55)    w_next = S_PRE;
                else if (RXD == 8'hD5)    w_next = S_HDR;
                else                      w_next = S_WAIT;
            end
            S_HDR: begin
                if (!RX_DV || RX_ER)                w_next = S_WAIT;
                else if (r_cnt == 4'd5 && !w_dst_ok) w_next = S_WAIT;
                else if (r_cnt == 4'd13)            w_next = w_match ? S_PAY : S_WAIT;
            end
            S_PAY:  if (!RX_DV) w_next = S_IDLE;
            default: w_next = S_WAIT;
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge RX_CLK or posedge rst) begin
        if (rst) r_state <= S_WAIT;
        else     r_state <= w_next;
    end

    // ---------------- datapath and registered outputs ----------------
    always_ff @(posedge RX_CLK or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_dst     <= '0;
            r_et_hi   <= '0;
            r_crc     <= '0;
            for (int i = 0; i < 4; i++) r_dly[i] <= '0;
            r_dly_cnt <= '0;
            r_err     <= 1'b0;
            r_plen    <= '0;
            r_first   <= 1'b0;
            r_data    <= '0;
            r_valid   <= '0;
            r_sof     <= 1'b0;
            r_eof     <= 1'b0;
            r_good    <= 1'b0;
            r_len     <= '0;
            r_ch      <= '0;
        end else begin
            r_valid <= '0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            if (w_sfd) begin
                r_cnt     <= '0;
                r_crc     <= 32'hFFFF_FFFF;
                r_dly_cnt <= '0;
                r_err     <= 1'b0;
                r_plen    <= '0;
                r_first   <= 1'b1;
            end
            if (r_state == S_HDR && RX_DV) begin
                r_crc <= f_crc8(r_crc, RXD);
                r_cnt <= r_cnt + 4'd1;
                r_dst <= {r_dst[31:0], RXD};
                if (r_cnt == 4'd12) r_et_hi <= RXD;
                if (r_cnt == 4'd13 && w_match) r_ch <= w_ch_sel;
            end
            if (r_state == S_PAY && RX_DV) begin
                if (RX_ER) r_err <= 1'b1;
                if (w_full) begin
                    // Oldest byte is now known not to be FCS: forward it.
                    r_data         <= r_dly[0];
                    r_valid[r_ch]  <= 1'b1;
                    r_sof          <= r_first;
                    r_first        <= 1'b0;
                    r_crc          <= f_crc8(r_crc, r_dly[0]);
                    if (r_plen != 11'h7FF) r_plen <= r_plen + 11'd1;
                    r_dly[0]       <= r_dly[1];
                    r_dly[1]       <= r_dly[2];
                    r_dly[2]       <= r_dly[3];
                    r_dly[3]       <= RXD;
                end else begin
                    r_dly[r_dly_cnt[1:0]] <= RXD;
                    r_dly_cnt             <= r_dly_cnt + 3'd1;
                end
            end
            if (w_eof) begin
                r_eof  <= 1'b1;
                r_good <= w_good;
                r_len  <= r_plen;
            end
        end
    end

    assign rx_data  = r_data;
    assign rx_valid = r_valid;
    assign rx_sof   = r_sof;
    assign rx_eof   = r_eof;
    assign rx_good  = r_good;
    assign rx_len   = r_len;
    assign rx_ch    = r_ch;

    // w_emit is folded into the PAY branch above; kept as a named qualifier
    // for readability of the output path.
    logic w_unused;
    assign w_unused = w_emit;

endmodule
`default_nettype wire
